strassen_seq_mm: RTL and testbench
==================================

STRASSEN_SEQ_MM -- requirements
Module: strassen_seq_mm

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: signed element width in bits, minimum 4.
REQ-002 SHALL have derived localparam BUSWIDTH = 16*DATAWIDTH: one packed 4x4 matrix.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: A/B/mode present.
REQ-006 SHALL have port in_ready, output, 1: block accepts a transaction.
REQ-007 SHALL have port A, input, BUSWIDTH: signed 4x4 operand.
REQ-008 SHALL have port B, input, BUSWIDTH: signed 4x4 operand.
REQ-009 SHALL have port mode, input, 1: 0 = full product; 1 = column-broadcast product.
REQ-010 SHALL have port out_valid, output, 1: C_out holds a finished result.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port C_out, output, BUSWIDTH: signed 4x4 result.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL pack element (r,c), with r and c in 0..3, at bits [(4r+c)*DATAWIDTH +: DATAWIDTH] in A, B and C_out.
REQ-015 SHALL form block Xij (i,j in 0..1) from elements (2i+u, 2j+v), u,v in 0..1, ordered row-major.
REQ-016 SHALL capture A, B and mode into internal registers on the edge where in_valid && in_ready; inputs SHALL be ignored at all other times.
REQ-017 SHALL implement the FSM states IDLE, MULT, COMB and DONE.
- IDLE: accept -> MULT.
- MULT: after the last product -> COMB.
- COMB: after one cycle -> DONE.
- DONE: on out_valid && out_ready -> IDLE.
REQ-018 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-019 SHALL use exactly one shared 2x2 block multiplier, producing one Strassen product per MULT cycle under a product counter.
REQ-020 SHALL, in mode 0, compute M1..M7 in order (7 MULT cycles):
- M1 = (A00+A11)(B00+B11)
- M2 = (A10+A11)B00
- M3 = A00(B01−B11)
- M4 = A11(B10−B00)
- M5 = (A00+A01)B11
- M6 = (A10−A00)(B00+B01)
- M7 = (A01−A11)(B10+B11)
REQ-021 SHALL, in mode 0, combine in COMB as C00 = M1+M4−M5+M7, C01 = M3+M5, C10 = M2+M4, C11 = M1−M2+M3+M6.
REQ-022 SHALL, in mode 1, treat B01 as B00 and B11 as B10, ignoring the right half of B.
REQ-023 SHALL, in mode 1, compute only M2, M3, M4 and M5, in that order (4 MULT cycles).
REQ-024 SHALL, in mode 1, combine as C00 = C01 = M3+M5 and C10 = C11 = M2+M4.
REQ-025 SHALL perform all additions, subtractions and multiplications modulo 2^DATAWIDTH, keeping the low DATAWIDTH bits with no saturation; each C_out element SHALL equal the true matrix product mod 2^DATAWIDTH.
REQ-026 SHALL write C_out on the COMB edge, which also asserts out_valid.
REQ-027 SHALL make out_valid rise exactly P+1 cycles after the accept edge, where P = 7 in mode 0 and P = 4 in mode 1.
REQ-028 SHALL hold C_out and out_valid stable in DONE while out_ready = 0, for any duration.
REQ-029 SHALL keep C_out at its last value after leaving DONE, until the next COMB edge.
REQ-030 SHALL, on the handshake edge in DONE, go to IDLE so that in_ready = 1 the following cycle; there SHALL be no same-cycle accept in DONE.
REQ-031 SHALL NOT let a mode change on the input mid-transaction affect the transaction in progress.

Reset
REQ-032 SHALL, with rst high at a clock edge, force state IDLE and clear the product counter, internal A/B/M/mode registers, C_out, out_valid and busy to 0.
REQ-033 SHALL, while rst is high, drive in_ready = 0; in_ready SHALL become 1 in the first cycle after rst is released.
REQ-034 SHALL, on reset during MULT, COMB or DONE, discard the transaction with no out_valid pulse.

Verification
REQ-035 SHALL pass: DATAWIDTH = 32, A = identity, B elements 1..16 row-major, mode 0 -> C_out = B; out_valid rises 8 cycles after accept.
REQ-036 SHALL pass: DATAWIDTH = 8, all A and B elements = 127, mode 0 -> every C_out element = 4 (64516 mod 256).
REQ-037 SHALL pass: A = identity, B elements 1..16, mode 1 -> C_out rows = {1,2,1,2}, {5,6,5,6}, {9,10,9,10}, {13,14,13,14}; latency 5 cycles.
REQ-038 SHALL pass: out_ready held 0 for 10 cycles in DONE while in_valid = 1 -> C_out and out_valid stable, in_ready = 0, no new capture.
REQ-039 SHALL pass: rst pulsed on the 3rd MULT cycle -> next cycle in_ready = 1, out_valid = 0, C_out = 0; a following transaction gives a correct result.
REQ-040 SHALL pass: 100 random signed back-to-back transactions of mixed mode with random out_ready -> every result matches the reference model mod 2^DATAWIDTH, and in_ready returns exactly one cycle after each output handshake.

Source files
------------

// File: rtl/strassen_seq_mm.sv
// Sequential 4x4 signed matrix multiplier: one shared 2x2 block multiplier steps through
// the Strassen products, then one combine cycle assembles the 4x4 result.
module strassen_seq_mm #(
    parameter int DATAWIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*DATAWIDTH-1:0]   A,
    input  logic [16*DATAWIDTH-1:0]   B,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*DATAWIDTH-1:0]   C_out,
    output logic                      busy
);
    localparam int DW       = DATAWIDTH;
    localparam int BUSWIDTH = 16 * DW;
    localparam int KW       = 4 * DW;

    typedef enum logic [1:0] {IDLE, MULT, COMB, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q;
    logic [BUSWIDTH-1:0]   a_q, b_q, c_q;
    logic                  mode_q;
    logic [KW-1:0]         m_q [7];

    logic [BUSWIDTH-1:0]   a_blk, b_blk, c_blk, c_new;
    logic [KW-1:0]         a00, a01, a10, a11, b00, b01, b11, b10;
    logic [KW-1:0]         op_l, op_r, prod;
    logic [KW-1:0]         c00, c01, c10, c11;
    logic [2:0]            pidx;
    logic                  accept, last_prod;

    function automatic logic [KW-1:0] blk_add(input logic [KW-1:0] x, input logic [KW-1:0] y);
        logic [KW-1:0] r;
        for (int e = 0; e < 4; e++) r[e*DW +: DW] = x[e*DW +: DW] + y[e*DW +: DW];
        return r;
    endfunction

    function automatic logic [KW-1:0] blk_sub(input logic [KW-1:0] x, input logic [KW-1:0] y);
        logic [KW-1:0] r;
        for (int e = 0; e < 4; e++) r[e*DW +: DW] = x[e*DW +: DW] - y[e*DW +: DW];
        return r;
    endfunction

    function automatic logic [KW-1:0] blk_mul(input logic [KW-1:0] x, input logic [KW-1:0] y);
        logic [KW-1:0] r;
        for (int u = 0; u < 2; u++) begin
            for (int v = 0; v < 2; v++) begin
                r[(2*u+v)*DW +: DW] = x[(2*u)*DW +: DW] * y[v*DW +: DW]
                                    + x[(2*u+1)*DW +: DW] * y[(2+v)*DW +: DW];
            end
        end
        return r;
    endfunction

    // Block-flat layout: block index 2i+j, element 2u+v inside each block.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_blk
            localparam int BI = gi / 4;
            localparam int EI = gi % 4;
            localparam int R  = 2 * (BI / 2) + EI / 2;
            localparam int C  = 2 * (BI % 2) + EI % 2;
            assign a_blk[gi*DW +: DW]          = a_q[(4*R+C)*DW +: DW];
            assign b_blk[gi*DW +: DW]          = b_q[(4*R+C)*DW +: DW];
            assign c_new[(4*R+C)*DW +: DW]     = c_blk[gi*DW +: DW];
        end
    endgenerate

    assign a00 = a_blk[0*KW +: KW];
    assign a01 = a_blk[1*KW +: KW];
    assign a10 = a_blk[2*KW +: KW];
    assign a11 = a_blk[3*KW +: KW];
    assign b00 = b_blk[0*KW +: KW];
    assign b10 = b_blk[2*KW +: KW];
    // Column-broadcast mode mirrors the left half of B into the right half.
    assign b01 = mode_q ? b_blk[0*KW +: KW] : b_blk[1*KW +: KW];
    assign b11 = mode_q ? b_blk[2*KW +: KW] : b_blk[3*KW +: KW];

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign C_out     = c_q;
    assign accept    = in_valid && in_ready;
    assign pidx      = mode_q ? cnt_q + 3'd1 : cnt_q;
    assign last_prod = mode_q ? (cnt_q == 3'd3) : (cnt_q == 3'd6);

    always_comb begin
        op_l = a00;
        op_r = b00;
        case (pidx)
            3'd0: begin op_l = blk_add(a00, a11); op_r = blk_add(b00, b11); end
            3'd1: begin op_l = blk_add(a10, a11); op_r = b00;               end
            3'd2: begin op_l = a00;               op_r = blk_sub(b01, b11); end
            3'd3: begin op_l = a11;               op_r = blk_sub(b10, b00); end
            3'd4: begin op_l = blk_add(a00, a01); op_r = b11;               end
            3'd5: begin op_l = blk_sub(a10, a00); op_r = blk_add(b00, b01); end
            default: begin op_l = blk_sub(a01, a11); op_r = blk_add(b10, b11); end
        endcase
    end

    assign prod = blk_mul(op_l, op_r);

    assign c01 = blk_add(m_q[2], m_q[4]);
    assign c10 = blk_add(m_q[1], m_q[3]);
    assign c00 = mode_q ? c01 : blk_add(blk_sub(blk_add(m_q[0], m_q[3]), m_q[4]), m_q[6]);
    assign c11 = mode_q ? c10 : blk_add(blk_add(blk_sub(m_q[0], m_q[1]), m_q[2]), m_q[5]);
    assign c_blk = {c11, c10, c01, c00};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MULT;
            MULT:    if (last_prod) state_d = COMB;
            COMB:    state_d = DONE;
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            c_q    <= '0;
            for (int i = 0; i < 7; i++) m_q[i] <= '0;
        end else begin
            if (accept) begin
                a_q    <= A;
                b_q    <= B;
                mode_q <= mode;
                cnt_q  <= '0;
            end
            if (state_q == MULT) begin
                m_q[pidx] <= prod;
                cnt_q     <= last_prod ? 3'd0 : cnt_q + 3'd1;
            end
            if (state_q == COMB) c_q <= c_new;
        end
    end
endmodule

// File: tb/tb_strassen_seq_mm.sv
// Scoreboard bench for strassen_seq_mm: stimulus pushes expected results, a monitor
// pops and compares on every output handshake and checks output latency.
module tb_strassen_seq_mm;
    localparam int DW = 32;
    localparam int BW = 16 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          mode = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] A = '0, B = '0;
    logic          in_ready, out_valid, busy;
    logic [BW-1:0] C_out;

    logic          in_valid8 = 1'b0;
    logic [127:0]  A8 = {16{8'd127}}, B8 = {16{8'd127}};
    logic          in_ready8, out_valid8, busy8;
    logic [127:0]  C8;

    strassen_seq_mm #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .C_out(C_out), .busy(busy)
    );

    strassen_seq_mm #(.DATAWIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(A8), .B(B8),
        .mode(1'b0), .out_valid(out_valid8), .out_ready(1'b1), .C_out(C8), .busy(busy8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;
    int ordy_mode = 0;
    logic [BW-1:0] exp_q[$];
    int            lat_q[$];
    logic [BW-1:0] ident, seq, e37;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic logic [BW-1:0] mm_ref(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                             input logic m);
        logic [BW-1:0] r;
        logic [DW-1:0] acc;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc += a[(4*rr+k)*DW +: DW] * b[(4*k + (m ? cc % 2 : cc))*DW +: DW];
                r[(4*rr+cc)*DW +: DW] = acc;
            end
        end
        return r;
    endfunction

    // out_ready: 0 = always high, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? 1'($urandom % 2) : 1'b0;
        end
    end

    initial begin
        logic ov_prev = 1'b0, hs_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin ov_prev = 1'b0; hs_pend = 1'b0; continue; end
            if (hs_pend) begin
                chk("in_ready_after_hs", BW'(in_ready), BW'(1));
                hs_pend = 1'b0;
            end
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) chk("unexpected_valid", BW'(out_valid), BW'(0));
                else chk("latency", BW'(cyc), BW'(lat_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", BW'(out_valid), BW'(0));
                else begin
                    chk("result", C_out, exp_q.pop_front());
                    void'(lat_q.pop_front());
                end
                hs_pend = 1'b1;
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic m,
                        input logic [BW-1:0] exp);
        int n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin chk("send_timeout", BW'(in_ready), BW'(1)); return; end
        in_valid = 1'b1; A = a; B = b; mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = ~m; A = {16{32'hdeadbeef}}; B = ~b;
        exp_q.push_back(exp);
        lat_q.push_back(cyc + (m ? 4 : 7) + 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0) chk("drain_timeout", BW'(exp_q.size()), BW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int e37v[16] = '{1, 2, 1, 2, 5, 6, 5, 6, 9, 10, 9, 10, 13, 14, 13, 14};
        logic [BW-1:0] ra, rb;
        logic rm;
        for (int i = 0; i < 16; i++) begin
            ident[i*DW +: DW] = (i % 5 == 0) ? 32'd1 : 32'd0;
            seq[i*DW +: DW]   = DW'(i + 1);
            e37[i*DW +: DW]   = DW'(e37v[i]);
        end

        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", BW'(in_ready), BW'(0));
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        rst = 1'b0; #1;
        chk("post_rst_in_ready", BW'(in_ready), BW'(1));
        chk("post_rst_busy", BW'(busy), BW'(0));
        chk("post_rst_c", C_out, '0);

        @(posedge clk); #1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
        chk("dw8_all127", BW'(C8), BW'({16{8'd4}}));

        send(ident, seq, 1'b0, seq);
        send(ident, seq, 1'b1, e37);
        send(seq, ident, 1'b0, seq);
        wait_drain();

        ordy_mode = 2;
        @(posedge clk); #1;
        send(seq, ident, 1'b1, e37);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b1; A = seq; B = seq; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", BW'(out_valid), BW'(1));
            chk("hold_c", C_out, e37);
            chk("hold_in_ready", BW'(in_ready), BW'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ordy_mode = 0;
        wait_drain();

        send(ident, seq, 1'b0, seq);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        chk("midrst_in_ready", BW'(in_ready), BW'(1));
        chk("midrst_out_valid", BW'(out_valid), BW'(0));
        chk("midrst_c", C_out, '0);
        chk("midrst_busy", BW'(busy), BW'(0));
        send(seq, ident, 1'b0, seq);
        wait_drain();

        ordy_mode = 1;
        for (int t = 0; t < 100; t++) begin
            for (int i = 0; i < 16; i++) begin
                ra[i*DW +: DW] = $urandom;
                rb[i*DW +: DW] = $urandom;
            end
            rm = 1'($urandom % 2);
            send(ra, rb, rm, mm_ref(ra, rb, rm));
        end
        wait_drain();
        ordy_mode = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
